// File: rtl/breakout_pkg.sv
// Shared Breakout constants: screen geometry, paddle size, FSM states, direction codes.
// Latency: none (types and constants only).
// Backpressure: none.
package breakout_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int W_BAR = 64;
  localparam int H_BAR = 8;
  localparam int BAR_Y = 464;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    MOVE  = 2'd1,
    LOST  = 2'd2,
    OVER  = 2'd3
  } state_t;

  // One bit per axis: 0 = left/up, 1 = right/down.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/ball_collide.sv
// Next ball position/direction from the current one: wall, paddle reflection and bottom exit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit the result.
module ball_collide
  import breakout_pkg::*;
#(
  parameter int R    = 4,
  parameter int STEP = 4
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_dx,
  input  logic       i_dy,
  input  logic [9:0] i_bar_x,
  input  logic [9:0] i_bar_y,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_dx,
  output logic       o_dy,
  output logic       o_hit,
  output logic       o_out
);

  // All comparisons are done in 12 bits and rearranged so nothing is subtracted
  // before comparing; that keeps small coordinates from wrapping.
  localparam logic [11:0] C_R     = 12'(R);
  localparam logic [11:0] C_STEP  = 12'(STEP);
  localparam logic [11:0] C_REACH = 12'(W_BAR + R);
  localparam logic [11:0] C_LIFT  = 12'(H_BAR + R);
  localparam logic [11:0] C_XMAX  = 12'(H_RES - R);
  localparam logic [11:0] C_YMAX  = 12'(V_RES - R);

  logic [11:0] w_x;
  logic [11:0] w_y;
  logic [11:0] w_bx;
  logic [11:0] w_by;
  logic        w_top;
  logic        w_pad;

  assign w_x  = {2'b00, i_x};
  assign w_y  = {2'b00, i_y};
  assign w_bx = {2'b00, i_bar_x};
  assign w_by = {2'b00, i_bar_y};

  assign w_top = (i_dy == DIR_UP) && (w_y <= C_R + C_STEP);

  // Paddle catch only on the tick that crosses the paddle top, within reach of its centre.
  assign w_pad = (i_dy == DIR_DOWN)
              && (w_y + C_STEP + C_LIFT >= w_by)
              && (w_y + C_LIFT < w_by + C_STEP)
              && (w_x + C_REACH >= w_bx)
              && (w_x <= w_bx + C_REACH);

  assign o_hit = w_top | w_pad;

  // Horizontal: side walls, then the paddle steers dx by which half was struck.
  always_comb begin
    o_x  = i_x;
    o_dx = i_dx;
    if ((i_dx == DIR_LEFT) && (w_x <= C_R + C_STEP)) begin
      o_x  = 10'(R);
      o_dx = DIR_RIGHT;
    end else if ((i_dx == DIR_RIGHT) && (w_x + C_STEP >= C_XMAX)) begin
      o_x  = 10'(H_RES - R);
      o_dx = DIR_LEFT;
    end else if (i_dx == DIR_RIGHT) begin
      o_x = i_x + 10'(STEP);
    end else begin
      o_x = i_x - 10'(STEP);
    end
    if (w_pad) begin
      if (w_x < w_bx) begin
        o_dx = DIR_LEFT;
      end else if (w_x > w_bx) begin
        o_dx = DIR_RIGHT;
      end
    end
  end

  // Vertical: top wall, paddle beats bottom exit, otherwise a plain step.
  always_comb begin
    o_y   = i_y;
    o_dy  = i_dy;
    o_out = 1'b0;
    if (w_top) begin
      o_y  = 10'(R);
      o_dy = DIR_DOWN;
    end else if (w_pad) begin
      o_y  = i_bar_y - 10'(H_BAR + R);
      o_dy = DIR_UP;
    end else if ((i_dy == DIR_DOWN) && (w_y + C_STEP >= C_YMAX)) begin
      o_out = 1'b1;
    end else if (i_dy == DIR_DOWN) begin
      o_y = i_y + 10'(STEP);
    end else begin
      o_y = i_y - 10'(STEP);
    end
  end

endmodule

// File: rtl/ball.sv
// Breakout ball: serve on paddle, move on tick, reflect, track lives; area flags scanned pixel.
// Latency: x/y/lives/lost/game_over registered (1 cycle); area combinational.
// Backpressure: none; tick and brick_hit are single-cycle strobes, never stalled.
module ball
  import breakout_pkg::*;
#(
  parameter int R          = 4,
  parameter int STEP       = 4,
  parameter int LIVES      = 3,
  parameter int LOST_TICKS = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       launch_n,
  input  logic [9:0] bar_x,
  input  logic [9:0] bar_y,
  input  logic       brick_hit,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       area,
  output logic [1:0] lives,
  output logic       lost,
  output logic       game_over
);

  localparam int CW = $clog2(LOST_TICKS + 1);

  state_t          r_state;
  logic [9:0]      r_x;
  logic [9:0]      r_y;
  logic            r_dx;
  logic            r_dy;
  logic [1:0]      r_lives;
  logic            r_lost;
  logic            r_game_over;
  logic            r_flag;
  logic [CW-1:0]   r_cnt;

  logic [9:0]      w_nx;
  logic [9:0]      w_ny;
  logic            w_ndx;
  logic            w_ndy;
  logic            w_hit;
  logic            w_out;
  logic            w_flag_now;
  logic            w_dy_next;

  ball_collide #(
    .R    (R),
    .STEP (STEP)
  ) u_collide (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_dx    (r_dx),
    .i_dy    (r_dy),
    .i_bar_x (bar_x),
    .i_bar_y (bar_y),
    .o_x     (w_nx),
    .o_y     (w_ny),
    .o_dx    (w_ndx),
    .o_dy    (w_ndy),
    .o_hit   (w_hit),
    .o_out   (w_out)
  );

  // A brick strobe arriving with the tick counts for that tick; a wall/paddle
  // reflection on the same tick wins and the pending brick bounce is dropped.
  assign w_flag_now = r_flag | brick_hit;
  assign w_dy_next  = (w_flag_now && !w_hit) ? ~w_ndy : w_ndy;

  // Serve/move/lost/over sequencing with all ball state and outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= SERVE;
      r_x         <= 10'(H_RES / 2);
      r_y         <= 10'(BAR_Y - H_BAR - R);
      r_dx        <= DIR_RIGHT;
      r_dy        <= DIR_UP;
      r_lives     <= 2'(LIVES);
      r_lost      <= 1'b0;
      r_game_over <= 1'b0;
      r_flag      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_lost <= 1'b0;
      case (r_state)
        SERVE: begin
          r_x    <= bar_x;
          r_y    <= bar_y - 10'(H_BAR + R);
          r_flag <= 1'b0;
          if (!launch_n) begin
            r_state <= MOVE;
            r_dx    <= DIR_RIGHT;
            r_dy    <= DIR_UP;
          end
        end
        MOVE: begin
          if (tick) begin
            r_flag <= 1'b0;
            if (w_out) begin
              r_lost  <= 1'b1;
              r_lives <= (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
              r_cnt   <= '0;
              r_state <= LOST;
            end else begin
              r_x  <= w_nx;
              r_y  <= w_ny;
              r_dx <= w_ndx;
              r_dy <= w_dy_next;
            end
          end else if (brick_hit) begin
            r_flag <= 1'b1;
          end
        end
        LOST: begin
          r_flag <= 1'b0;
          if (tick) begin
            if (r_cnt == CW'(LOST_TICKS - 1)) begin
              r_cnt <= '0;
              if (r_lives != 2'd0) begin
                r_state <= SERVE;
              end else begin
                r_state     <= OVER;
                r_game_over <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        OVER: begin
          r_flag      <= 1'b0;
          r_game_over <= 1'b1;
        end
        default: r_state <= SERVE;
      endcase
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign lives     = r_lives;
  assign lost      = r_lost;
  assign game_over = r_game_over;

  // Square ball footprint test against the pixel being scanned (11 bits, no wrap).
  always_comb begin
    area = ({1'b0, next_x} + 11'(R) >= {1'b0, r_x})
        && ({1'b0, next_x} <= {1'b0, r_x} + 11'(R))
        && ({1'b0, next_y} + 11'(R) >= {1'b0, r_y})
        && ({1'b0, next_y} <= {1'b0, r_y} + 11'(R));
  end

endmodule

// File: tb/tb_ball.sv
// Bench for ball: reference model feeds a per-cycle scoreboard, plus directed scenario checks.
// Latency: expected values queued as each cycle is driven, popped after the edge.
// Backpressure: not applicable.
module tb_ball;

  localparam int R          = 4;
  localparam int STEP       = 4;
  localparam int LIVES      = 3;
  localparam int LOST_TICKS = 32;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       launch_n;
  logic [9:0] bar_x;
  logic [9:0] bar_y;
  logic       brick_hit;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic [9:0] x;
  logic [9:0] y;
  logic       area;
  logic [1:0] lives;
  logic       lost;
  logic       game_over;

  ball #(
    .R          (R),
    .STEP       (STEP),
    .LIVES      (LIVES),
    .LOST_TICKS (LOST_TICKS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .launch_n  (launch_n),
    .bar_x     (bar_x),
    .bar_y     (bar_y),
    .brick_hit (brick_hit),
    .next_x    (next_x),
    .next_y    (next_y),
    .x         (x),
    .y         (y),
    .area      (area),
    .lives     (lives),
    .lost      (lost),
    .game_over (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: 0 serve, 1 move, 2 lost, 3 over.
  int m_st, m_x, m_y, m_dx, m_dy, m_lives, m_lost, m_go, m_flag, m_cnt;
  logic [23:0] sb[$];

  task automatic model_cycle();
    int bx, by, pt, nx, ny, ndx, ndy;
    bit top, pad, bot, f;
    bx = int'(bar_x);
    by = int'(bar_y);
    if (reset) begin
      m_st = 0; m_x = 320; m_y = 452; m_dx = 1; m_dy = 0;
      m_lives = LIVES; m_lost = 0; m_go = 0; m_flag = 0; m_cnt = 0;
      return;
    end
    m_lost = 0;
    case (m_st)
      0: begin
        m_x = bx;
        m_y = by - 8 - R;
        if (!launch_n) begin m_st = 1; m_dx = 1; m_dy = 0; end
      end
      1: begin
        if (tick) begin
          f  = (m_flag != 0) || brick_hit;
          pt = by - 8 - R;
          ndx = m_dx;
          if (m_dx == 0 && m_x <= R + STEP) begin nx = R; ndx = 1; end
          else if (m_dx == 1 && m_x + STEP >= 640 - R) begin nx = 640 - R; ndx = 0; end
          else nx = (m_dx == 1) ? m_x + STEP : m_x - STEP;
          top = (m_dy == 0) && (m_y <= R + STEP);
          pad = (m_dy == 1) && (m_y + STEP >= pt) && (m_y < pt + STEP)
                && (m_x + 64 + R >= bx) && (m_x <= bx + 64 + R);
          bot = (m_dy == 1) && (m_y + STEP >= 480 - R) && !pad;
          ndy = m_dy;
          if (top) begin ny = R; ndy = 1; end
          else if (pad) begin
            ny = pt; ndy = 0;
            if (m_x < bx) ndx = 0; else if (m_x > bx) ndx = 1;
          end else ny = (m_dy == 1) ? m_y + STEP : m_y - STEP;
          if (f && !top && !pad) ndy = 1 - ndy;
          m_flag = 0;
          if (bot) begin
            m_lost = 1;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_st = 2; m_cnt = 0;
          end else begin
            m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
          end
        end else if (brick_hit) m_flag = 1;
      end
      2: begin
        if (tick) begin
          if (m_cnt == LOST_TICKS - 1) begin
            m_cnt = 0;
            if (m_lives != 0) m_st = 0;
            else begin m_st = 3; m_go = 1; end
          end else m_cnt++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step();
    logic [23:0] e;
    model_cycle();
    sb.push_back({10'(m_x), 10'(m_y), 2'(m_lives), 1'(m_lost), 1'(m_go)});
    @(posedge clock);
    @(negedge clock);
    e = sb.pop_front();
    check("cycle", {8'h0, x, y, lives, lost, game_over}, {8'h0, e});
  endtask

  task automatic tick_once(input logic b);
    tick = 1'b1; brick_hit = b;
    step();
    tick = 1'b0; brick_hit = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic serve_launch(input int bx, input int by);
    bar_x = 10'(bx); bar_y = 10'(by);
    step();
    launch_n = 1'b0;
    step();
    launch_n = 1'b1;
  endtask

  task automatic area_chk(input string tag, input int px, input int py, input logic exp);
    next_x = 10'(px); next_y = 10'(py);
    #1;
    check(tag, {31'h0, area}, {31'h0, exp});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; tick = 1'b0; launch_n = 1'b1; brick_hit = 1'b0;
    bar_x = 10'd200; bar_y = 10'd464; next_x = '0; next_y = '0;
    step(); step();
    check("rst_x", 32'(x), 320);
    check("rst_y", 32'(y), 452);
    check("rst_lives", 32'(lives), 3);
    check("rst_lost", 32'(lost), 0);
    check("rst_go", 32'(game_over), 0);

    // Serve follows the paddle with one cycle of latency.
    reset = 1'b0;
    step();
    check("serve_x", 32'(x), 200);
    check("serve_y", 32'(y), 452);
    area_chk("area_in_corner", 204, 456, 1'b1);
    area_chk("area_out_right", 205, 452, 1'b0);
    area_chk("area_in_lo", 196, 448, 1'b1);
    area_chk("area_out_left", 195, 452, 1'b0);
    area_chk("area_out_below", 200, 457, 1'b0);
    area_chk("area_out_above", 200, 447, 1'b0);
    bar_x = 10'd210;
    step();
    check("follow_x", 32'(x), 210);
    bar_x = 10'd200;
    step();
    launch_n = 1'b0;
    step();
    launch_n = 1'b1;
    repeat (3) step();
    check("idle_no_move", 32'(x), 200);
    tick_once(1'b0);
    check("first_move_x", 32'(x), 204);
    check("first_move_y", 32'(y), 448);

    // Top-right corner reflects both axes, then the low paddle catches it.
    do_reset();
    serve_launch(632, 20);
    tick_once(1'b0);
    check("corner_x", 32'(x), 636);
    check("corner_y", 32'(y), 4);
    tick_once(1'b0);
    check("corner2_x", 32'(x), 632);
    check("corner2_y", 32'(y), 8);

    // Left wall: paddle near the top steers the ball left until it hits x=8.
    do_reset();
    serve_launch(40, 24);
    bar_x = 10'd60;
    repeat (16) tick_once(1'b0);
    check("lw_approach_x", 32'(x), 8);
    tick_once(1'b0);
    check("lw_bounce_x", 32'(x), 4);
    tick_once(1'b0);
    check("lw_after_x", 32'(x), 8);

    // Paddle hit from y=449 moving down, left of paddle centre.
    do_reset();
    serve_launch(296, 465);
    tick_once(1'b1);
    check("pad_setup_y", 32'(y), 449);
    bar_x = 10'd320; bar_y = 10'd464;
    tick_once(1'b0);
    check("pad_hit_y", 32'(y), 452);
    tick_once(1'b0);
    check("pad_after_x", 32'(x), 300);
    check("pad_after_y", 32'(y), 448);

    // Brick flag pending when the top wall reflects: wall wins, flag dropped.
    do_reset();
    serve_launch(300, 20);
    bar_x = 10'd600;
    brick_hit = 1'b1; step(); brick_hit = 1'b0;
    tick_once(1'b0);
    check("bt_top_y", 32'(y), 4);
    tick_once(1'b0);
    check("bt_down1_y", 32'(y), 8);
    tick_once(1'b0);
    check("bt_down2_y", 32'(y), 12);
    brick_hit = 1'b1; step(); brick_hit = 1'b0;
    tick_once(1'b0);
    check("brick_flip_y", 32'(y), 16);
    tick_once(1'b0);
    check("brick_up_y", 32'(y), 12);

    // Misses until the game is over.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      serve_launch(96, 489);
      tick_once(1'b1);
      bar_x = 10'd500; bar_y = 10'd464;
      tick = 1'b1; step(); tick = 1'b0;
      check("miss_lost_pulse", 32'(lost), 1);
      check("miss_lives", 32'(lives), 32'(2 - i));
      step();
      check("miss_lost_drop", 32'(lost), 0);
      repeat (LOST_TICKS - 1) tick_once(1'b0);
      check("lost_frozen_x", 32'(x), 100);
      tick_once(1'b0);
      if (i < 2) check("reserve_x", 32'(x), 500);
    end
    check("over_go", 32'(game_over), 1);
    check("over_lives", 32'(lives), 0);
    launch_n = 1'b0;
    tick_once(1'b0);
    launch_n = 1'b1;
    tick_once(1'b1);
    check("over_frozen_x", 32'(x), 100);
    check("over_frozen_y", 32'(y), 473);

    // Reset from OVER restores everything.
    do_reset();
    check("rst2_x", 32'(x), 320);
    check("rst2_lives", 32'(lives), 3);
    check("rst2_go", 32'(game_over), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ball.md
# ball

Ball-motion stage of the Breakout datapath: consumes the paddle position (`bar_x`, `bar_y`) produced by the paddle block, advances a ball on each movement tick, and reflects it off the walls, the paddle and bricks. It also manages serve, ball-loss and lives. It sits between the paddle block and the pixel colour mux, which consumes `x`, `y` and `area`.

## Interface
- `R`, 4: ball half-size in pixels.
- `STEP`, 4: pixels moved per tick on each axis.
- `LIVES`, 3: lives loaded at reset.
- `LOST_TICKS`, 32: ticks spent in LOST before the next serve.
- `clock` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock `clock`.
- `tick` in 1: one-cycle movement strobe from the shared timer.
- `launch_n` in 1: serve button, active-low.
- `bar_x` in 10: paddle centre x.
- `bar_y` in 10: paddle centre y.
- `brick_hit` in 1: one-cycle strobe from the brick stage; reverse vertical direction.
- `next_x` in 10: pixel x currently being scanned.
- `next_y` in 10: pixel y currently being scanned.
- `x` out 10: ball centre x, registered.
- `y` out 10: ball centre y, registered.
- `area` out 1: combinational; the scanned pixel lies inside the ball.
- `lives` out 2: remaining lives, registered.
- `lost` out 1: one-cycle pulse when the ball leaves the bottom edge.
- `game_over` out 1: level signal; high once lives reach 0.

## Operation
- **States:**
  - SERVE: ball rides the paddle; `x = bar_x`, `y = bar_y - 8 - R` (452 at the default `bar_y` of 464), updated every cycle. On `launch_n == 0`, go to MOVE with dx = right and dy = up.
  - MOVE: advances on `tick` only.
  - LOST: count `LOST_TICKS` ticks. Then go to SERVE if `lives != 0`, otherwise go to OVER.
  - OVER: hold the ball frozen with `game_over = 1` until reset.
- **Per-tick rules in MOVE.** Evaluate on the current `x`/`y`. Compare before adding or subtracting, so nothing underflows.
  - Left wall: dx left and `x <= R+STEP` → `x = R`, dx = right.
  - Right wall: dx right and `x + STEP >= 640-R` → `x = 640-R`, dx = left.
  - Otherwise: `x ± STEP`.
  - Top wall: dy up and `y <= R+STEP` → `y = R`, dy = down.
  - Paddle: requires all of dy down, `y + STEP >= bar_y-8-R`, `y < bar_y-8-R+STEP` (only when crossing the paddle top), `x + 64 + R >= bar_x` and `x <= bar_x + 64 + R`. Result: `y = bar_y-8-R`, dy = up. dx becomes left if `x < bar_x`, right if `x > bar_x`, and is unchanged if equal.
  - Bottom: dy down and `y + STEP >= 480-R` with no paddle hit → pulse `lost`, decrement `lives` (saturating at 0), go to LOST.
  - Otherwise: `y ± STEP`.
- **brick_hit.** Latched into a sticky flag. On the next tick in MOVE the flag clears and dy inverts, unless a top-wall or paddle reflection happens on that same tick; those take priority and the flag is dropped. The flag is also cleared on leaving MOVE.
- **Priority:** paddle > bottom. x and y rules are independent, so a corner reflects both axes on the same tick.
- **area:** `next_x + R >= x && next_x <= x + R && next_y + R >= y && next_y <= y + R`.

## Timing
- **Reset values:** state SERVE, `x = 320`, `y = 452`, dx = right, dy = up, `lives = LIVES`, `lost = 0`, `game_over = 0`, brick flag = 0, LOST counter = 0.
- Reset mid-operation restores all reset values on the next edge.
- In MOVE, `x`/`y` change exactly one cycle after a `tick` cycle and never without one.
- In SERVE, `x`/`y` follow `bar_*` with a 1-cycle latency.
- The launch is sampled every cycle in SERVE. MOVE is entered on the next edge; the first move happens on the first tick after that.
- `lost` is high for exactly the cycle after the bottom-exit tick.
- `lives` updates on the same edge as `lost`.
- `game_over` rises on the edge of the LOST→OVER transition.
- `tick` and `brick_hit` in the same cycle: the flag is applied on that tick.

## Structure
- Shared package `breakout_pkg` holds:
  - `H_RES = 640`, `V_RES = 480`
  - `W_BAR = 64`, `H_BAR = 8`, `BAR_Y = 464`
  - state enum: SERVE, MOVE, LOST, OVER
  - direction encoding: 0 = left/up, 1 = right/down
- One sub-module `ball_collide`: purely combinational next-position/next-direction computation plus the `hit`/`out` flags. The FSM, registers and counters stay in `ball`.

## Test plan
- **Reset, then serve-follow:** reset, then `bar_x = 200` → `x = 200`, `y = 452`, `lives = 3`; `launch_n` low → MOVE; one tick later `x = 204`, `y = 448`.
- **Left wall:** ball at `x = 8` moving left/up, tick → `x = 4`, dx = right; next tick `x = 8`.
- **Top-right corner:** ball at `x = 632`, `y = 8`, right/up, tick → `x = 636`, `y = 4`, dx = left, dy = down.
- **Paddle hit:** ball at `x = 300`, `y = 449`, moving down, `bar_x = 320`, tick → `y = 452`, dy = up, dx = left.
- **Miss:**
  - ball at `x = 100`, `y = 473`, down, `bar_x = 500`, tick → `lost` pulses once, `lives = 2`; after 32 ticks state is SERVE.
  - repeated until `lives = 0` → `game_over = 1`, ball frozen.
- **Brick plus top wall on the same tick:** `brick_hit` pulsed, then tick at `y = 8` moving up → dy = down, flag cleared; the next tick moves down.
